// File: rtl/arctan.sv
// arctan -- fully pipelined CORDIC (vectoring mode) computing atan2(iny, inx)
// in Q16.16 radians, one sample per cycle, no stalls.
//
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : synchronous active-low reset, clears every pipeline register
//   in_valid  : qualifies inx/iny on the current rising edge
//   inx, iny  : signed 32-bit coordinates (integer units, scale-free)
//   out_valid : one-cycle pulse per accepted sample, in order
//   out       : signed atan2(iny, inx) * 65536, rounded, in [-pi, +pi] codes
//
// Pipeline: normalise -> pre-rotate -> ITER CORDIC stages -> output register.
// Result appears after edge N+ITER+2 for a sample accepted at edge N.
module arctan #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] inx,
    input  logic [31:0] iny,
    output logic        out_valid,
    output logic [31:0] out
);
    localparam int LAT = ITER + 1;
    localparam logic signed [31:0] PI_Q = 32'sd205887;

    function automatic logic signed [31:0] atan_lut(input int i);
        case (i)
            0:  return 32'sd51472;
            1:  return 32'sd30386;
            2:  return 32'sd16055;
            3:  return 32'sd8150;
            4:  return 32'sd4091;
            5:  return 32'sd2047;
            6:  return 32'sd1024;
            7:  return 32'sd512;
            8:  return 32'sd256;
            9:  return 32'sd128;
            10: return 32'sd64;
            11: return 32'sd32;
            12: return 32'sd16;
            13: return 32'sd8;
            14: return 32'sd4;
            15: return 32'sd2;
            16: return 32'sd1;
            default: return 32'sd0;
        endcase
    endfunction

    // Count of redundant sign bits (how far v can be shifted left without
    // changing its sign). Zero gives 31.
    function automatic logic [4:0] cls(input logic [31:0] v);
        logic [4:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int b = 30; b >= 0; b--) begin
            if (run && (v[b] == v[31])) n = n + 5'd1;
            else                         run = 1'b0;
        end
        return n;
    endfunction

    // Normalisation: scale both coordinates by the same power of two so the
    // larger one uses the full word. The angle is unchanged, and tiny inputs
    // such as (1,1) no longer lose the CORDIC residual to integer truncation.
    logic [4:0]         shx, shy, sh_d;
    logic signed [31:0] nx_d, ny_d, nx_q, ny_q;
    logic               zero_d;

    always_comb begin
        shx    = cls(inx);
        shy    = cls(iny);
        sh_d   = (shx < shy) ? shx : shy;
        nx_d   = $signed(inx << sh_d);
        ny_d   = $signed(iny << sh_d);
        zero_d = (inx == 32'd0) && (iny == 32'd0);
    end

    // x/y only needed up to the input of the last iteration; z through it.
    logic signed [34:0] x_q [0:ITER-1];
    logic signed [34:0] y_q [0:ITER-1];
    logic signed [31:0] z_q [0:ITER];
    logic signed [34:0] x0_d, y0_d;
    logic signed [31:0] z0_d;

    // Pre-rotation into the right half-plane; 35-bit width lets -(-2^31)
    // and the CORDIC gain fit without wrapping.
    always_comb begin
        x0_d = {{3{nx_q[31]}}, nx_q};
        y0_d = {{3{ny_q[31]}}, ny_q};
        z0_d = '0;
        if (nx_q[31]) begin
            x0_d = -x0_d;
            y0_d = -y0_d;
            z0_d = ny_q[31] ? -PI_Q : PI_Q;
        end
    end

    logic [LAT+1:0] vld_pipe;
    logic [LAT:0]   zf_pipe;    // marks (0,0) samples, forced to 0 at output
    logic signed [31:0] zfin, out_d;

    always_comb begin
        zfin  = z_q[ITER];
        out_d = zfin;
        // residual error can push the angle just past +/-pi; pin it there
        if (zfin > PI_Q)       out_d = PI_Q;
        else if (zfin < -PI_Q) out_d = -PI_Q;
        if (zf_pipe[LAT])      out_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nx_q     <= '0;
            ny_q     <= '0;
            vld_pipe <= '0;
            zf_pipe  <= '0;
            out      <= '0;
            for (int i = 0; i < ITER; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            for (int i = 0; i <= ITER; i++) z_q[i] <= '0;
        end else begin
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            vld_pipe <= {vld_pipe[LAT:0], in_valid};
            zf_pipe  <= {zf_pipe[LAT-1:0], zero_d};
            x_q[0]   <= x0_d;
            y_q[0]   <= y0_d;
            z_q[0]   <= z0_d;
            // each iteration uses the pre-update x/y of the previous stage
            for (int i = 0; i < ITER - 1; i++) begin
                if (!y_q[i][34]) begin
                    x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
                    y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
                end else begin
                    x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
                    y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
                end
            end
            for (int i = 0; i < ITER; i++) begin
                if (!y_q[i][34]) z_q[i+1] <= z_q[i] + atan_lut(i);
                else             z_q[i+1] <= z_q[i] - atan_lut(i);
            end
            out <= out_d;
        end
    end

    assign out_valid = vld_pipe[LAT+1];

endmodule

// File: tb/tb_arctan.sv
// Self-checking bench for arctan: directed corner cases, random back-to-back
// traffic and a mid-flight reset, scored against a real-valued atan2 model
// with a fixed 18-edge arrival time.
module tb_arctan;
    localparam int LATENCY = 18;
    localparam int TOL     = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inx = '0, iny = '0;
    logic        out_valid;
    logic [31:0] out;

    arctan dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .inx(inx), .iny(iny), .out_valid(out_valid), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int expv;
        int due;
        bit exact;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int ref_atan(input logic signed [31:0] x, input logic signed [31:0] y);
        real a;
        if (x == 0 && y == 0) return 0;
        a = $atan2($itor(y), $itor(x)) * 65536.0;
        if (a >= 0.0) return $rtoi(a + 0.5);
        return -$rtoi(-a + 0.5);
    endfunction

    // Compare the DUT outputs for the edge just taken against the scoreboard.
    task automatic check_slot();
        logic want_v;
        int   got, d;
        logic ok;
        want_v = (q.size() > 0) && (q[0].due == cyc);
        n_cmp++;
        assert (out_valid === want_v) else begin
            n_bad++;
            $error("FAIL out_valid cyc=%0d: got %b want %b", cyc, out_valid, want_v);
        end
        if (want_v) begin
            got = $signed(out);
            d   = got - q[0].expv;
            ok  = q[0].exact ? (d == 0) : (d <= TOL && d >= -TOL);
            n_cmp++;
            assert (ok === 1'b1) else begin
                n_bad++;
                $error("FAIL angle cyc=%0d: got %0d want %0d (tol %0d)", cyc, got, q[0].expv,
                       q[0].exact ? 0 : TOL);
            end
            void'(q.pop_front());
        end
    endtask

    task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        in_valid = v;
        inx      = x;
        iny      = y;
        @(posedge clk);
        cyc++;
        if (!rst_n) q.delete();
        else if (v) begin
            e.expv  = ref_atan(x, y);
            e.due   = cyc + LATENCY;
            e.exact = (x == 0 && y == 0);
            q.push_back(e);
        end
        #1;
        check_slot();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom);
    endtask

    initial begin
        logic [31:0] rx, ry;

        // reset state, with a valid sample offered during reset (ignored)
        rst_n = 1'b0;
        step(1'b1, 32'd1, 32'd1);
        step(1'b0, 32'd0, 32'd0);
        n_cmp++;
        assert (out === 32'd0) else begin
            n_bad++;
            $error("FAIL reset_out: got %0d want 0", out);
        end
        rst_n = 1'b1;

        // isolated (1,1): checks exact 18-edge latency on its own
        step(1'b1, 32'd1, 32'd1);
        idle(LATENCY + 2);

        // directed corners, back to back
        step(1'b1, 32'd0, 32'd1);
        step(1'b1, 32'd0, -32'sd5);
        step(1'b1, -32'sd1, 32'd0);
        step(1'b1, -32'sd1, -32'sd1);
        step(1'b1, 32'd5, 32'd0);
        step(1'b1, 32'd0, 32'd0);
        step(1'b1, 32'h8000_0000, 32'h7fff_ffff);
        step(1'b1, 32'h4000_0000, 32'h4000_0000);
        step(1'b1, 32'h8000_0000, 32'd0);
        step(1'b1, 32'd0, 32'h8000_0000);
        step(1'b1, 32'h8000_0000, 32'h8000_0000);
        step(1'b1, -32'sd3, 32'd7);
        idle(LATENCY + 2);

        // 18 random samples, one per cycle, varied magnitudes
        for (int i = 0; i < 18; i++) begin
            rx = $signed($urandom) >>> $urandom_range(0, 30);
            ry = $signed($urandom) >>> $urandom_range(0, 30);
            step(1'b1, rx, ry);
        end
        idle(LATENCY + 2);

        // reset with 5 samples in flight: none may emerge
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, $urandom);
        rst_n = 1'b0;
        step(1'b1, 32'd3, 32'd4);
        n_cmp++;
        assert (out === 32'd0) else begin
            n_bad++;
            $error("FAIL midreset_out: got %0d want 0", out);
        end
        rst_n = 1'b1;
        idle(LATENCY + 5);

        // recovery after reset
        step(1'b1, 32'd3, 32'd4);
        idle(LATENCY + 2);

        n_cmp++;
        assert (q.size() === 0) else begin
            n_bad++;
            $error("FAIL drain: %0d results never arrived, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
